// File: rtl/ccff_chain_loader_pkg.sv
// Shared types and constants for the ccff chain loader: FSM states, sb_1__1_ chain geometry, clog2.
package ccff_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FETCH = 3'd1,
      SHIFT = 3'd2,
      DONE  = 3'd3,
      ERR   = 3'd4
   } state_t;

   // 8 size-9 muxes and 4 size-8 muxes, each 2-level: 8*8 + 4*6 = 88 config bits.
   localparam int MUX_SIZE9_CCFF_BITS = 8;
   localparam int MUX_SIZE8_CCFF_BITS = 6;
   localparam int SB_1_1_CHAIN_LEN    = 88;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/ccff_chain_loader_if.sv
// Bitstream word channel. A word transfers on any prog_clk edge where cfg_valid && cfg_ready.
interface ccff_chain_loader_if #(parameter int WORD_W = 32);
   logic [WORD_W-1:0] cfg_data;
   logic              cfg_valid;
   logic              cfg_ready;

   modport master (output cfg_data, output cfg_valid, input cfg_ready);
   modport slave  (input cfg_data, input cfg_valid, output cfg_ready);
endinterface

// File: rtl/ccff_chain_loader_stall_timer.sv
// Counts consecutive stalled FETCH cycles; term flags the STALL_MAX-th stalled cycle.
module ccff_stall_timer
   import ccff_pkg::*;
#(
   parameter int STALL_MAX = 1024
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic en,
   output logic term
);

   localparam int CW = (clog2(STALL_MAX) < 1) ? 1 : clog2(STALL_MAX);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst || clear) cnt <= '0;
      else if (en && !term) cnt <= cnt + 1'b1;
   end

   assign term = (cnt == CW'(STALL_MAX - 1));

endmodule

// File: rtl/ccff_chain_loader.sv
// Serializes bitstream words MSB-first into one ccff chain segment with a gated chain clock-enable.
// Define CCFF_LOADER_READBACK_EN to capture ccff_tail into rb_data/rb_valid while shifting.
module ccff_chain_loader
   import ccff_pkg::*;
#(
   parameter int CHAIN_LEN = 88,
   parameter int WORD_W    = 32,
   parameter int STALL_MAX = 1024
) (
   input  logic                prog_clk,
   input  logic                pReset,
   input  logic                start,
   ccff_chain_loader_if.slave  cfg,
   output logic                ccff_head,
   output logic                chain_en,
   input  logic                ccff_tail,
   output logic                busy,
   output logic                done,
   output logic                err,
`ifdef CCFF_LOADER_READBACK_EN
   output logic [WORD_W-1:0]   rb_data,
   output logic                rb_valid,
`endif
   output state_t              state
);

   localparam int BCW = clog2(CHAIN_LEN + 1);
   localparam int WBW = clog2(WORD_W + 1);

   state_t            nxt_state;
   logic [WORD_W-1:0] shift_reg, shift_nx;
   logic [BCW-1:0]    bit_cnt, bit_cnt_nx;
   logic [WBW-1:0]    word_bits, word_bits_nx;
   logic              err_nx;
   logic              stall_term;
   int                remaining;

   ccff_stall_timer #(.STALL_MAX(STALL_MAX)) u_stall_timer (
      .clk   (prog_clk),
      .rst   (pReset),
      .clear ((state != FETCH) || cfg.cfg_valid),
      .en    ((state == FETCH) && !cfg.cfg_valid),
      .term  (stall_term)
   );

   always_comb begin
      nxt_state    = state;
      shift_nx     = shift_reg;
      bit_cnt_nx   = bit_cnt;
      word_bits_nx = word_bits;
      err_nx       = err;
      remaining    = CHAIN_LEN - int'(bit_cnt);
      case (state)
         IDLE: begin
            if (start) begin
               nxt_state  = FETCH;
               err_nx     = 1'b0;
               bit_cnt_nx = '0;
            end
         end
         FETCH: begin
            if (cfg.cfg_valid) begin
               nxt_state    = SHIFT;
               shift_nx     = cfg.cfg_data;
               // Final word may be partial: its low-order leftovers are never shifted.
               word_bits_nx = WBW'((remaining < WORD_W) ? remaining : WORD_W);
            end else if (stall_term) begin
               nxt_state = ERR;
               err_nx    = 1'b1;
            end
         end
         SHIFT: begin
            shift_nx     = shift_reg << 1;
            bit_cnt_nx   = bit_cnt + 1'b1;
            word_bits_nx = word_bits - 1'b1;
            if (bit_cnt_nx == BCW'(CHAIN_LEN)) nxt_state = DONE;
            else if (word_bits == WBW'(1))     nxt_state = FETCH;
         end
         DONE:    nxt_state = IDLE;
         ERR:     nxt_state = IDLE;
         default: nxt_state = IDLE;
      endcase
   end

   // Outputs are registered from the next state so chain_en and ccff_head flip on the same edge.
   always_ff @(posedge prog_clk) begin
      if (pReset) begin
         state         <= IDLE;
         shift_reg     <= '0;
         bit_cnt       <= '0;
         word_bits     <= '0;
         err           <= 1'b0;
         chain_en      <= 1'b0;
         ccff_head     <= 1'b0;
         cfg.cfg_ready <= 1'b0;
         busy          <= 1'b0;
         done          <= 1'b0;
      end else begin
         state         <= nxt_state;
         shift_reg     <= shift_nx;
         bit_cnt       <= bit_cnt_nx;
         word_bits     <= word_bits_nx;
         err           <= err_nx;
         chain_en      <= (nxt_state == SHIFT);
         ccff_head     <= (nxt_state == SHIFT) && shift_nx[WORD_W-1];
         cfg.cfg_ready <= (nxt_state == FETCH);
         busy          <= (nxt_state == FETCH) || (nxt_state == SHIFT);
         done          <= (nxt_state == DONE);
      end
   end

`ifdef CCFF_LOADER_READBACK_EN
   logic [WORD_W-1:0] cap, cap_nx;
   logic [WORD_W:0]   cap_ext;
   logic [WBW-1:0]    cap_cnt;

   assign cap_ext = {cap, ccff_tail};
   assign cap_nx  = cap_ext[WORD_W-1:0];

   // The old chain contents fall out of the tail while the new bits go in at the head.
   always_ff @(posedge prog_clk) begin
      if (pReset) begin
         cap      <= '0;
         cap_cnt  <= '0;
         rb_data  <= '0;
         rb_valid <= 1'b0;
      end else begin
         rb_valid <= 1'b0;
         if (state == SHIFT) begin
            if ((cap_cnt == WBW'(WORD_W - 1)) || (bit_cnt_nx == BCW'(CHAIN_LEN))) begin
               rb_valid <= 1'b1;
               rb_data  <= cap_nx << (WORD_W - 1 - int'(cap_cnt));
               cap      <= '0;
               cap_cnt  <= '0;
            end else begin
               cap     <= cap_nx;
               cap_cnt <= cap_cnt + 1'b1;
            end
         end else if (state == IDLE) begin
            cap     <= '0;
            cap_cnt <= '0;
         end
      end
   end
`else
   logic unused_tail;
   assign unused_tail = ccff_tail;
`endif

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Directed bench for ccff_chain_loader: 88-bit chain, 32-bit words, 16-cycle stall limit.
module tb_ccff_chain_loader;
   import ccff_pkg::*;

   localparam int CHAIN_LEN = 88;
   localparam int WORD_W    = 32;
   localparam int STALL_MAX = 16;

   logic   prog_clk = 1'b0;
   logic   pReset, start, ccff_tail, ccff_head, chain_en, busy, done, err;
   state_t dut_state;
   ccff_chain_loader_if #(.WORD_W(WORD_W)) cfg_bus ();
`ifdef CCFF_LOADER_READBACK_EN
   logic [WORD_W-1:0] rb_data;
   logic              rb_valid;
   logic [WORD_W-1:0] rb_q[$];
`endif

   int checks = 0, errors = 0;
   int cyc = 0, en_count = 0, ready_count = 0, done_count = 0, overlap = 0;
   int done_cyc = 0, start_cyc = 0;
   bit err_seen = 0;
   logic [0:0] head_q[$];
   logic [0:0] exp_q[$];
   logic [WORD_W-1:0] words[3];
   bit src_on = 0;
   int src_max = 3, gap_word = 99, gap_len = 0;
   logic [CHAIN_LEN-1:0] chain = '0;
   bit preload = 0;

   ccff_chain_loader #(.CHAIN_LEN(CHAIN_LEN), .WORD_W(WORD_W), .STALL_MAX(STALL_MAX)) dut (
      .prog_clk  (prog_clk),
      .pReset    (pReset),
      .start     (start),
      .cfg       (cfg_bus),
      .ccff_head (ccff_head),
      .chain_en  (chain_en),
      .ccff_tail (ccff_tail),
      .busy      (busy),
      .done      (done),
      .err       (err),
`ifdef CCFF_LOADER_READBACK_EN
      .rb_data   (rb_data),
      .rb_valid  (rb_valid),
`endif
      .state     (dut_state)
   );

   always #5 prog_clk = ~prog_clk;

   // Chain model: captures ccff_head on every enabled edge.
   always @(posedge prog_clk) begin
      if (preload) chain <= '1;
      else if (chain_en) chain <= {chain[CHAIN_LEN-2:0], ccff_head};
   end
   assign ccff_tail = chain[CHAIN_LEN-1];

   always @(negedge prog_clk) begin
      cyc++;
      if (chain_en) begin
         head_q.push_back(ccff_head);
         en_count++;
         if (cfg_bus.cfg_ready) overlap++;
      end
      if (cfg_bus.cfg_ready) ready_count++;
      if (done) begin
         done_count++;
         done_cyc = cyc;
      end
      if (err) err_seen = 1;
`ifdef CCFF_LOADER_READBACK_EN
      if (rb_valid) rb_q.push_back(rb_data);
`endif
   end

   // Bitstream source: offers words[idx]; optionally withholds word gap_word for gap_len FETCH cycles.
   initial begin : source
      logic hs;
      bit   active;
      int   idx, gap_left;
      cfg_bus.cfg_valid = 1'b0;
      cfg_bus.cfg_data  = '0;
      active = 0; idx = 0; gap_left = 0;
      forever begin
         @(negedge prog_clk);
         hs = cfg_bus.cfg_valid && cfg_bus.cfg_ready;
         if (active && !cfg_bus.cfg_valid && cfg_bus.cfg_ready && idx == gap_word && gap_left > 0)
            gap_left--;
         @(posedge prog_clk); #1;
         if (!src_on) begin
            active = 0;
            cfg_bus.cfg_valid = 1'b0;
         end else begin
            if (!active) begin
               active = 1; idx = 0; gap_left = gap_len;
            end else if (hs) idx++;
            cfg_bus.cfg_valid = (idx < src_max) && !(idx == gap_word && gap_left > 0);
            cfg_bus.cfg_data  = (idx < 3) ? words[idx] : '0;
         end
      end
   end

   task automatic do_reset();
      src_on = 0; start = 1'b0; pReset = 1'b1;
      repeat (3) @(posedge prog_clk);
      #1 pReset = 1'b0;
   endtask

   task automatic clear_mon();
      en_count = 0; ready_count = 0; done_count = 0; overlap = 0; done_cyc = 0;
      err_seen = 0;
      head_q.delete();
`ifdef CCFF_LOADER_READBACK_EN
      rb_q.delete();
`endif
   endtask

   task automatic build_exp();
      logic [WORD_W-1:0] w;
      exp_q.delete();
      for (int i = 0; i < CHAIN_LEN; i++) begin
         w = words[i / WORD_W];
         exp_q.push_back(w[WORD_W - 1 - (i % WORD_W)]);
      end
   endtask

   function automatic int head_errors();
      int bad = 0;
      if (head_q.size() != exp_q.size()) bad++;
      for (int i = 0; i < head_q.size() && i < exp_q.size(); i++)
         if (head_q[i] !== exp_q[i]) bad++;
      return bad;
   endfunction

   // Start is sampled on the second edge; the next negedge is cycle 1 of the load.
   task automatic pulse_start();
      @(posedge prog_clk); #1 start = 1'b1;
      @(posedge prog_clk); #1 start = 1'b0;
      start_cyc = cyc;
   endtask

   task automatic wait_end(input int budget, output bit timed_out);
      timed_out = 1;
      for (int i = 0; i < budget; i++) begin
         @(posedge prog_clk);
         if (done_count > 0 || err_seen) begin
            timed_out = 0;
            break;
         end
      end
   endtask

   task automatic test_reset();
      pReset = 1'b1; start = 1'b1;
      repeat (3) @(posedge prog_clk);
      #1 pReset = 1'b0; start = 1'b0;
      @(negedge prog_clk);
      checks++;
      if ({chain_en, ccff_head, busy, done, err, cfg_bus.cfg_ready} !== 6'b0 || dut_state !== IDLE) begin
         errors++;
         $display("FAIL reset_outputs: got %b state %0d expected 000000 state 0",
                  {chain_en, ccff_head, busy, done, err, cfg_bus.cfg_ready}, dut_state);
      end
      repeat (3) @(negedge prog_clk);
      checks++;
      if (busy !== 1'b0 || dut_state !== IDLE) begin
         errors++;
         $display("FAIL reset_start_ignored: got busy %b state %0d expected busy 0 state 0", busy, dut_state);
      end
   endtask

   task automatic test_basic_load();
      bit to;
      words = '{32'hA5A5A5A5, 32'h0F0F0F0F, 32'hFFFFFF3C};
      src_max = 3; gap_word = 99; gap_len = 0;
      do_reset(); clear_mon(); build_exp();
      src_on = 1;
      pulse_start();
      @(negedge prog_clk);
      checks++;
      if (dut_state !== FETCH || cfg_bus.cfg_ready !== 1'b1 || busy !== 1'b1 || chain_en !== 1'b0) begin
         errors++;
         $display("FAIL basic_first_fetch: got state %0d ready %b busy %b en %b expected 1 1 1 0",
                  dut_state, cfg_bus.cfg_ready, busy, chain_en);
      end
      wait_end(300, to);
      repeat (4) @(posedge prog_clk);
      checks++;
      if (to) begin errors++; $display("FAIL basic_timeout: got no done expected done within 300 cycles"); end
      checks++;
      if (en_count !== 88) begin errors++; $display("FAIL basic_en_count: got %0d expected 88", en_count); end
      checks++;
      if (head_errors() !== 0) begin errors++; $display("FAIL basic_head_seq: got %0d bit errors expected 0", head_errors()); end
      checks++;
      if (done_count !== 1) begin errors++; $display("FAIL basic_done_count: got %0d expected 1", done_count); end
      // 1+32 + 1+32 + 1+24 FETCH/SHIFT cycles, then DONE.
      checks++;
      if (done_cyc - start_cyc !== 92) begin errors++; $display("FAIL basic_done_cycle: got %0d expected 92", done_cyc - start_cyc); end
      checks++;
      if (ready_count !== 3 || overlap !== 0 || err_seen !== 0) begin
         errors++;
         $display("FAIL basic_handshake: got ready %0d overlap %0d err %0d expected 3 0 0", ready_count, overlap, err_seen);
      end
   endtask

   task automatic test_stall_gap();
      bit to;
      words = '{32'hA5A5A5A5, 32'h0F0F0F0F, 32'hFFFFFF3C};
      src_max = 3; gap_word = 1; gap_len = 10;
      do_reset(); clear_mon(); build_exp();
      src_on = 1;
      pulse_start();
      wait_end(300, to);
      repeat (4) @(posedge prog_clk);
      checks++;
      if (to || err_seen) begin errors++; $display("FAIL gap_completion: got timeout %0d err %0d expected 0 0", to, err_seen); end
      checks++;
      if (en_count !== 88 || head_errors() !== 0) begin
         errors++;
         $display("FAIL gap_bits: got %0d shifts %0d bit errors expected 88 0", en_count, head_errors());
      end
      checks++;
      if (overlap !== 0 || ready_count !== 13) begin
         errors++;
         $display("FAIL gap_fetch: got overlap %0d ready %0d expected 0 13", overlap, ready_count);
      end
      checks++;
      if (done_cyc - start_cyc !== 102 || done_count !== 1) begin
         errors++;
         $display("FAIL gap_done: got cycle %0d count %0d expected 102 1", done_cyc - start_cyc, done_count);
      end
   endtask

   task automatic test_stall_timeout();
      bit to;
      words = '{32'hA5A5A5A5, 32'h0F0F0F0F, 32'hFFFFFF3C};
      src_max = 1; gap_word = 99; gap_len = 0;
      do_reset(); clear_mon();
      src_on = 1;
      pulse_start();
      wait_end(300, to);
      repeat (2) @(posedge prog_clk);
      @(negedge prog_clk);
      checks++;
      if (to || err !== 1'b1) begin errors++; $display("FAIL timeout_err: got timeout %0d err %b expected 0 1", to, err); end
      checks++;
      if (busy !== 1'b0 || chain_en !== 1'b0 || dut_state !== IDLE) begin
         errors++;
         $display("FAIL timeout_idle: got busy %b en %b state %0d expected 0 0 0", busy, chain_en, dut_state);
      end
      checks++;
      if (done_count !== 0 || en_count !== 32 || ready_count !== 17) begin
         errors++;
         $display("FAIL timeout_counts: got done %0d shifts %0d ready %0d expected 0 32 17", done_count, en_count, ready_count);
      end
      pulse_start();
      @(negedge prog_clk);
      checks++;
      if (err !== 1'b0 || dut_state !== FETCH) begin
         errors++;
         $display("FAIL timeout_err_clear: got err %b state %0d expected 0 1", err, dut_state);
      end
   endtask

   task automatic test_reset_mid_load();
      bit to;
      words = '{32'h12345678, 32'h9ABCDEF0, 32'hC3C3C3FF};
      src_max = 3; gap_word = 99; gap_len = 0;
      do_reset(); clear_mon();
      src_on = 1;
      pulse_start();
      for (int i = 0; i < 200 && en_count < 40; i++) @(posedge prog_clk);
      #1 pReset = 1'b1; src_on = 0;
      @(posedge prog_clk);
      @(negedge prog_clk);
      checks++;
      if ({chain_en, ccff_head, busy, done, err, cfg_bus.cfg_ready} !== 6'b0 || dut_state !== IDLE || done_count !== 0) begin
         errors++;
         $display("FAIL midreset_outputs: got %b state %0d done %0d expected 000000 0 0",
                  {chain_en, ccff_head, busy, done, err, cfg_bus.cfg_ready}, dut_state, done_count);
      end
      @(posedge prog_clk); #1 pReset = 1'b0;
      clear_mon(); build_exp();
      src_on = 1;
      pulse_start();
      wait_end(300, to);
      repeat (4) @(posedge prog_clk);
      checks++;
      if (to || en_count !== 88 || done_count !== 1 || head_errors() !== 0) begin
         errors++;
         $display("FAIL midreset_reload: got timeout %0d shifts %0d done %0d bit errors %0d expected 0 88 1 0",
                  to, en_count, done_count, head_errors());
      end
   endtask

   task automatic test_start_ignored();
      bit to;
      words = '{32'hDEADBEEF, 32'h00FF00FF, 32'h5A5A5A00};
      src_max = 3; gap_word = 99; gap_len = 0;
      do_reset(); clear_mon(); build_exp();
      src_on = 1;
      pulse_start();
      for (int i = 0; i < 200 && en_count < 20; i++) @(posedge prog_clk);
      #1 start = 1'b1;
      @(posedge prog_clk); #1 start = 1'b0;
      wait_end(300, to);
      repeat (4) @(posedge prog_clk);
      checks++;
      if (to || en_count !== 88 || head_errors() !== 0) begin
         errors++;
         $display("FAIL busy_start_bits: got timeout %0d shifts %0d bit errors %0d expected 0 88 0", to, en_count, head_errors());
      end
      checks++;
      if (done_count !== 1 || done_cyc - start_cyc !== 92) begin
         errors++;
         $display("FAIL busy_start_done: got count %0d cycle %0d expected 1 92", done_count, done_cyc - start_cyc);
      end
   endtask

`ifdef CCFF_LOADER_READBACK_EN
   task automatic test_readback();
      bit to;
      words = '{32'h0, 32'h0, 32'h0};
      src_max = 3; gap_word = 99; gap_len = 0;
      do_reset();
      @(posedge prog_clk); #1 preload = 1;
      @(posedge prog_clk); #1 preload = 0;
      clear_mon();
      src_on = 1;
      pulse_start();
      wait_end(300, to);
      repeat (4) @(posedge prog_clk);
      checks++;
      if (to || rb_q.size() !== 3) begin errors++; $display("FAIL rb_count: got timeout %0d pulses %0d expected 0 3", to, rb_q.size()); end
      checks++;
      if (rb_q.size() == 3 && (rb_q[0] !== 32'hFFFFFFFF || rb_q[1] !== 32'hFFFFFFFF || rb_q[2] !== 32'hFFFFFF00)) begin
         errors++;
         $display("FAIL rb_data: got %h %h %h expected ffffffff ffffffff ffffff00", rb_q[0], rb_q[1], rb_q[2]);
      end
      checks++;
      if (chain !== '0) begin errors++; $display("FAIL rb_chain_zero: got %h expected 0", chain); end
   endtask
`endif

   initial begin
      pReset = 1'b1; start = 1'b0;
      test_reset();
      test_basic_load();
      test_stall_gap();
      test_stall_timeout();
      test_reset_mid_load();
      test_start_ignored();
`ifdef CCFF_LOADER_READBACK_EN
      test_readback();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ccff_chain_loader.md
Name: ccff_chain_loader

Overview:
- Programming-domain controller that serializes a configuration bitstream into one switch-block configuration-chain (ccff) segment.
- Accepts words from a bitstream source over a valid/ready handshake and shifts them bit-serially into ccff_head.
- Drives a clock-enable to the chain's clock gate so the chain advances only on valid bits.
- Counts exactly CHAIN_LEN bits (88 for an sb with 8 size-9 and 4 size-8 2-level muxes), then reports done; reports err on source stall timeout.

Parameters:
- CHAIN_LEN, 88, total ccff bits in the chain segment (>=1).
- WORD_W, 32, bitstream word width (>=1).
- STALL_MAX, 1024, consecutive cycles without cfg_valid while a word is needed before err (>=1).

Ports:
- prog_clk  in  1  programming clock.
- pReset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a load when idle.
- cfg_data  in  WORD_W  bitstream word; bit WORD_W-1 is shifted first.
- cfg_valid  in  1  cfg_data valid.
- cfg_ready  out  1  word accepted when cfg_valid && cfg_ready.
- ccff_head  out  1  serial bit to chain head.
- chain_en  out  1  chain clock-enable; chain captures ccff_head on prog_clk when 1.
- ccff_tail  in  1  chain tail (used only with readback).
- busy  out  1  load in progress.
- done  out  1  one-cycle pulse when last bit is shifted.
- err  out  1  sticky stall-timeout flag; cleared by start or pReset.

Behaviour:
- Reset is synchronous, active-high on pReset sampled at prog_clk. All outputs reset to 0, state IDLE, counters 0, shift register 0. pReset mid-load aborts immediately with no completion pulse; chain contents are undefined afterwards.
- States:
  - IDLE: start -> FETCH, clear err and bit_cnt.
  - FETCH: cfg_ready=1. On handshake, load the word into the shift register, set word_bits = min(WORD_W, CHAIN_LEN - bit_cnt) -> SHIFT. With no valid, increment stall_cnt; at stall_cnt == STALL_MAX-1 -> ERR.
  - SHIFT: chain_en=1, ccff_head = shift_reg[WORD_W-1]. Each cycle shift left by 1, bit_cnt++, word_bits--. When bit_cnt reaches CHAIN_LEN -> DONE. When word_bits reaches 0 -> FETCH.
  - DONE: done=1 for one cycle -> IDLE.
  - ERR: err=1 (sticky), chain_en=0 -> IDLE.
- Registered outputs:
  - chain_en and ccff_head change together, so the chain shifts on the prog_clk edge where chain_en=1.
  - Exactly CHAIN_LEN cycles with chain_en=1 per successful load.
- Word width and padding:
  - Number of words = ceil(CHAIN_LEN/WORD_W).
  - Unused low-order bits of the final word are discarded and never shifted.
- Handshake and stall rules:
  - cfg_ready is 1 only in FETCH, so a word handshake never overlaps shifting. Minimum one FETCH cycle per word.
  - stall_cnt resets on every handshake and on leaving FETCH.
- busy=1 in FETCH and SHIFT.
- start while busy is ignored. start coincident with pReset is ignored.
- bit_cnt width is clog2(CHAIN_LEN+1).

Optional Feature:
- Macro CCFF_LOADER_READBACK_EN.
- When defined:
  - Adds outputs rb_data[WORD_W] and rb_valid.
  - Each SHIFT cycle, ccff_tail is shifted into a capture register, LSB side.
  - rb_valid pulses for one cycle with the captured word once WORD_W bits are captured, or at DONE. A partial final word is left-aligned with zero fill.
  - Readback yields the previous chain contents in shift-out order.
- When undefined: ccff_tail is unused and there are no rb ports.

Decomposition:
- Shared package ccff_pkg holds:
  - state enum (IDLE, FETCH, SHIFT, DONE, ERR);
  - localparam SB_1_1_CHAIN_LEN = 88;
  - function clog2 and per-mux chain widths (size9 = 8, size8 = 6).
- One sub-module, ccff_stall_timer: counter with clear, enable and STALL_MAX terminal flag.

Test Plan:
- CHAIN_LEN=88, WORD_W=32, words 0xA5A5A5A5, 0x0F0F0F0F, 0xFFFFFFxx with source always valid -> exactly 88 chain_en cycles, ccff_head sequence equals the first 88 MSB-first bits, done at cycle 88+3 fetch cycles after start.
- Source drops cfg_valid for 10 cycles before word 2 -> chain_en=0 during the gap, no err, final bit count 88.
- STALL_MAX=16, source never valid after word 1 -> err=1 after 16 FETCH cycles, chain_en held 0, busy=0, no done.
- pReset asserted at bit 40 -> next cycle all outputs 0, IDLE; new start loads 88 bits cleanly.
- start pulsed at bit 20 -> ignored, still exactly 88 shifts and one done.
- Readback (macro on): preload the chain model with 88 ones, load zeros -> rb_data = 0xFFFFFFFF, 0xFFFFFFFF, 0xFFFFFF00, three rb_valid pulses.
